i2c_target: RTL and testbench

- I2C target (slave) endpoint that sits on the same SDA/SCL bus downstream of the I2C_master peripheral.
- Responds to one 7-bit address.
- Captures up to 4 bytes of a write transfer into a 32-bit receive word, and serves up to 4 bytes from a 32-bit transmit word on a read transfer.
- Used as a loopback/endpoint peripheral and as the on-chip bus partner in system tests. Fully synchronous to clk_i: SCL/SDA are oversampled, never used as clocks.

---
 rtl/i2c_target.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : i2c_target                                                     |
// | Purpose  : Oversampled I2C target; 4-byte write capture, 4-byte read.     |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module i2c_target #(
  parameter logic [6:0]  TGT_ADDR    = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [31:0] tx_data_i,
  output logic [31:0] rx_data_o,
  output logic [2:0]  rx_count_o,
  output logic        rx_valid_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_RX_BYTE  = 3'd3,
    S_RX_ACK   = 3'd4,
    S_TX_BYTE  = 3'd5,
    S_TX_ACK   = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic        r_scl_prev, r_sda_prev;
  logic [6:0]  r_shift;
  logic [2:0]  r_bit_cnt, r_byte_cnt;
  logic [31:0] r_rx_buf, r_tx_buf;
  logic        r_rw, r_wr_active, r_ack_phase, r_ack_ok, r_tx_first;
  logic        r_sda_oe, r_rx_valid, r_busy;
  logic [31:0] r_rx_data;
  logic [2:0]  r_rx_count;

  logic       w_scl_s, w_sda_s;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_byte_done, w_addr_hit;
  logic [7:0] w_full_byte, w_tx_byte;
  logic [2:0] w_bit_m1;

  assign w_scl_s     = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s     = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise  = w_scl_s & ~r_scl_prev;
  assign w_scl_fall  = ~w_scl_s & r_scl_prev;
  assign w_start     = w_scl_s & r_scl_prev & ~w_sda_s & r_sda_prev;
  assign w_stop      = w_scl_s & r_scl_prev & w_sda_s & ~r_sda_prev;
  assign w_byte_done = w_scl_rise & (r_bit_cnt == 3'd0);
  assign w_full_byte = {r_shift, w_sda_s};
  assign w_addr_hit  = (w_full_byte[7:1] == TGT_ADDR);
  assign w_bit_m1    = r_bit_cnt - 3'd1;
  // Bytes past the 4-byte window read as all-ones, i.e. SDA left released.
  assign w_tx_byte   = (r_byte_cnt < 3'd4) ? r_tx_buf[{r_byte_cnt[1:0], 3'b000} +: 8] : 8'hFF;

  assign sda_oe_o   = r_sda_oe;
  assign rx_data_o  = r_rx_data;
  assign rx_count_o = r_rx_count;
  assign rx_valid_o = r_rx_valid;
  assign busy_o     = r_busy;

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_ADDR:     if (w_byte_done) w_state_nxt = w_addr_hit ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: if (w_scl_fall && r_ack_phase) w_state_nxt = r_rw ? S_TX_BYTE : S_RX_BYTE;
        S_RX_BYTE:  if (w_byte_done) w_state_nxt = S_RX_ACK;
        S_RX_ACK:   if (w_scl_fall && r_ack_phase) w_state_nxt = S_RX_BYTE;
        S_TX_BYTE:  if (w_scl_fall && !r_tx_first && r_bit_cnt == 3'd0) w_state_nxt = S_TX_ACK;
        S_TX_ACK:   if (w_scl_rise) w_state_nxt = w_sda_s ? S_IGNORE : S_TX_BYTE;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_scl_sync  <= '1;
      r_sda_sync  <= '1;
      r_scl_prev  <= 1'b1;
      r_sda_prev  <= 1'b1;
      r_shift     <= '0;
      r_bit_cnt   <= 3'd7;
      r_byte_cnt  <= '0;
      r_rx_buf    <= '0;
      r_tx_buf    <= '0;
      r_rw        <= 1'b0;
      r_wr_active <= 1'b0;
      r_ack_phase <= 1'b0;
      r_ack_ok    <= 1'b0;
      r_tx_first  <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_count  <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_prev <= w_scl_s;
      r_sda_prev <= w_sda_s;
      r_state    <= w_state_nxt;
      r_rx_valid <= 1'b0;

      if (w_start || w_stop) begin
        // A bus condition ends any transfer; publish a write that stored data.
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b0;
        r_wr_active <= 1'b0;
        if (r_wr_active && r_byte_cnt != 3'd0) begin
          r_rx_data  <= r_rx_buf;
          r_rx_count <= r_byte_cnt;
          r_rx_valid <= 1'b1;
        end
        if (w_start) begin
          r_byte_cnt  <= '0;
          r_rx_buf    <= '0;
          r_bit_cnt   <= 3'd7;
          r_ack_phase <= 1'b0;
        end
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_full_byte[6:0];
              r_bit_cnt <= r_bit_cnt - 3'd1;
            end
            if (w_byte_done && w_addr_hit) begin
              r_busy      <= 1'b1;
              r_rw        <= w_full_byte[0];
              r_wr_active <= ~w_full_byte[0];
              r_ack_phase <= 1'b0;
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= 1'b1;
                r_ack_phase <= 1'b1;
              end else begin
                r_bit_cnt  <= 3'd7;
                r_tx_first <= 1'b0;
                if (r_rw) begin
                  r_tx_buf <= tx_data_i;
                  r_sda_oe <= ~tx_data_i[7];
                end else begin
                  r_sda_oe <= 1'b0;
                end
              end
            end
          end
          S_RX_BYTE: begin
            if (w_scl_rise) begin
              r_shift   <= w_full_byte[6:0];
              r_bit_cnt <= r_bit_cnt - 3'd1;
            end
            if (w_byte_done) begin
              r_ack_phase <= 1'b0;
              if (r_byte_cnt < 3'd4) begin
                r_rx_buf[{r_byte_cnt[1:0], 3'b000} +: 8] <= w_full_byte;
                r_byte_cnt <= r_byte_cnt + 3'd1;
                r_ack_ok   <= 1'b1;
              end else begin
                r_ack_ok   <= 1'b0;
              end
            end
          end
          S_RX_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= r_ack_ok;
                r_ack_phase <= 1'b1;
              end else begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 3'd7;
              end
            end
          end
          S_TX_BYTE: begin
            // After a master ACK the first fall presents bit 7 without counting.
            if (w_scl_fall) begin
              if (r_tx_first) begin
                r_sda_oe   <= ~w_tx_byte[7];
                r_tx_first <= 1'b0;
              end else if (r_bit_cnt == 3'd0) begin
                r_sda_oe <= 1'b0;
              end else begin
                r_sda_oe  <= ~w_tx_byte[w_bit_m1];
                r_bit_cnt <= w_bit_m1;
              end
            end
          end
          S_TX_ACK: begin
            if (w_scl_rise && !w_sda_s) begin
              if (r_byte_cnt < 3'd4) r_byte_cnt <= r_byte_cnt + 3'd1;
              r_bit_cnt  <= 3'd7;
              r_tx_first <= 1'b1;
            end
          end
          default: r_sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_i2c_target                                                  |
// | Purpose  : Directed bus-master stimulus with hand-computed expectations.  |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module tb_i2c_target;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_oe_o;
  logic [31:0] tx_data_i = 32'h0;
  logic [31:0] rx_data_o;
  logic [2:0]  rx_count_o;
  logic        rx_valid_o;
  logic        busy_o;
  logic        w_sda_bus;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_oe = 0;
  int n_busy = 0;

  assign w_sda_bus = m_sda & ~sda_oe_o;

  i2c_target #(.TGT_ADDR(7'h42), .SYNC_STAGES(2)) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (m_scl),
    .sda_i      (w_sda_bus),
    .sda_oe_o   (sda_oe_o),
    .tx_data_i  (tx_data_i),
    .rx_data_o  (rx_data_o),
    .rx_count_o (rx_count_o),
    .rx_valid_o (rx_valid_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (rx_valid_o) n_valid <= n_valid + 1;
    if (sda_oe_o)   n_oe    <= n_oe + 1;
    if (busy_o)     n_busy  <= n_busy + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic q();
    repeat (5) @(posedge clk_i);
    #1;
  endtask

  task automatic m_start();
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask

  task automatic m_stop();
    m_sda = 1'b0; q();
    m_scl = 1'b1; q();
    m_sda = 1'b1; q();
  endtask

  task automatic m_wbit(input logic b);
    m_sda = b; q();
    m_scl = 1'b1; q(); q();
    m_scl = 1'b0; q();
  endtask

  task automatic m_rbit(output logic b);
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    b = w_sda_bus; q();
    m_scl = 1'b0; q();
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) m_wbit(d[i]);
    m_rbit(ack_n);
  endtask

  task automatic m_rbyte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      m_rbit(b);
      d[i] = b;
    end
    m_wbit(nack);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         v0, o0, b0;
    logic [7:0] wr5 [5];
    wr5[0] = 8'h11; wr5[1] = 8'h22; wr5[2] = 8'h33; wr5[3] = 8'h44; wr5[4] = 8'h55;

    // Reset state
    repeat (4) @(posedge clk_i);
    #1;
    chk("rst_oe",    {31'd0, sda_oe_o},   32'd0);
    chk("rst_data",  rx_data_o,           32'd0);
    chk("rst_count", {29'd0, rx_count_o}, 32'd0);
    chk("rst_valid", {31'd0, rx_valid_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o},     32'd0);
    rst_i = 1'b1;
    q();

    // Write 1 byte
    v0 = n_valid;
    m_start();
    m_wbyte(8'h84, a); chk("w1_addr_ack", {31'd0, a}, 32'd0);
    m_wbyte(8'hA5, a); chk("w1_data_ack", {31'd0, a}, 32'd0);
    chk("w1_busy", {31'd0, busy_o}, 32'd1);
    m_stop(); q();
    chk("w1_data",   rx_data_o,           32'h000000A5);
    chk("w1_count",  {29'd0, rx_count_o}, 32'd1);
    chk("w1_pulses", n_valid - v0,        32'd1);
    chk("w1_busy_end", {31'd0, busy_o},   32'd0);

    // Write 5 bytes, 5th is NACKed
    v0 = n_valid;
    m_start();
    m_wbyte(8'h84, a); chk("w5_addr_ack", {31'd0, a}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      m_wbyte(wr5[i], a);
      chk($sformatf("w5_ack%0d", i), {31'd0, a}, (i == 4) ? 32'd1 : 32'd0);
    end
    m_stop(); q();
    chk("w5_data",   rx_data_o,           32'h44332211);
    chk("w5_count",  {29'd0, rx_count_o}, 32'd4);
    chk("w5_pulses", n_valid - v0,        32'd1);

    // Read 3 bytes
    v0 = n_valid;
    tx_data_i = 32'hDEADBEEF;
    m_start();
    m_wbyte(8'h85, a); chk("rd_addr_ack", {31'd0, a}, 32'd0);
    m_rbyte(1'b0, d);  chk("rd_b0", {24'd0, d}, 32'h000000EF);
    m_rbyte(1'b0, d);  chk("rd_b1", {24'd0, d}, 32'h000000BE);
    m_rbyte(1'b1, d);  chk("rd_b2", {24'd0, d}, 32'h000000AD);
    q();
    chk("rd_release", {31'd0, sda_oe_o}, 32'd0);
    m_stop(); q();
    chk("rd_pulses", n_valid - v0, 32'd0);
    chk("rd_data_hold", rx_data_o, 32'h44332211);

    // Wrong address
    v0 = n_valid; o0 = n_oe; b0 = n_busy;
    m_start();
    m_wbyte(8'h86, a); chk("wa_addr_nack", {31'd0, a}, 32'd1);
    m_wbyte(8'hA5, a); chk("wa_data_nack", {31'd0, a}, 32'd1);
    m_stop(); q();
    chk("wa_busy_cycles", n_busy - b0,        32'd0);
    chk("wa_oe_cycles",   n_oe - o0,          32'd0);
    chk("wa_pulses",      n_valid - v0,       32'd0);
    chk("wa_data",        rx_data_o,          32'h44332211);
    chk("wa_count",       {29'd0, rx_count_o}, 32'd4);

    // Repeated START after 4 data bits, then 1-byte read
    v0 = n_valid;
    tx_data_i = 32'h12345678;
    m_start();
    m_wbyte(8'h84, a); chk("rs_addr_ack", {31'd0, a}, 32'd0);
    m_wbit(1'b1); m_wbit(1'b0); m_wbit(1'b1); m_wbit(1'b0);
    m_start();
    m_wbyte(8'h85, a); chk("rs_raddr_ack", {31'd0, a}, 32'd0);
    m_rbyte(1'b1, d);  chk("rs_rd_b0", {24'd0, d}, 32'h00000078);
    m_stop(); q();
    chk("rs_pulses", n_valid - v0, 32'd0);
    chk("rs_data",   rx_data_o,    32'h44332211);

    // Reset while the address ACK is driven
    m_start();
    for (int i = 7; i >= 0; i--) m_wbit(8'h84 >> i);
    chk("ra_oe_driven", {31'd0, sda_oe_o}, 32'd1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("ra_oe_released", {31'd0, sda_oe_o}, 32'd0);
    rst_i = 1'b1;
    m_stop(); q();
    v0 = n_valid;
    m_start();
    m_wbyte(8'h84, a); chk("ra_addr_ack", {31'd0, a}, 32'd0);
    m_wbyte(8'h5A, a); chk("ra_data_ack", {31'd0, a}, 32'd0);
    m_stop(); q();
    chk("ra_data",   rx_data_o,           32'h0000005A);
    chk("ra_count",  {29'd0, rx_count_o}, 32'd1);
    chk("ra_pulses", n_valid - v0,        32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
